// File: rtl/mlu_sel_ctrl.sv
// Op sequencer for the ML unit: issues beats, tracks per-class result latency and steers out_sel.
// Optional stall counter (perf_stall_cnt) is built when SEL_CTRL_PERF_EN is defined.
module mlu_sel_ctrl #(
  parameter int K       = 20,
  parameter int CNT_W   = 16,
  parameter int LAT_VEC = 3,
  parameter int LAT_ACC = 5,
  parameter int LAT_NL  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op_code,
  input  logic [CNT_W-1:0] op_len,
  output logic             issue_en,
  output logic             pipe_en,
  output logic [2:0]       out_sel,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             op_done,
  output logic             err_op,
`ifdef SEL_CTRL_PERF_EN
  output logic [31:0]      perf_stall_cnt,
`endif
  output logic [1:0]       dbg_state
);

  localparam int LAT_MAX = (K > LAT_ACC) ? ((K > LAT_NL) ? K : LAT_NL)
                                         : ((LAT_ACC > LAT_NL) ? LAT_ACC : LAT_NL);
  localparam int LAT_W   = $clog2(LAT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   beat_rem;
  logic [CNT_W-1:0]   res_rem;
  logic               is_red;
  logic [LAT_W-1:0]   lat_cnt;
  logic [LAT_W-1:0]   lat_load;
  logic [LAT_VEC-1:0] tok;
  logic               accept;
  logic               legal;
  logic               hs;
  logic               last_beat;

  assign dbg_state = state;

  // Handshakes: a descriptor moves on a cycle with op_valid && op_ready, a result
  // moves on a cycle with res_valid && res_ready; neither valid waits on its ready.
  always_comb begin
    state_nxt = state;
    op_ready  = (state == S_IDLE);
    accept    = op_valid && op_ready;
    legal     = (op_code != 3'b000) && (op_code != 3'b111) && (op_len != '0);
    res_valid = is_red ? ((state == S_DRAIN) && (lat_cnt == '0)) : tok[LAT_VEC-1];
    pipe_en   = !(res_valid && !res_ready);
    issue_en  = (state == S_ISSUE) && pipe_en;
    hs        = res_valid && res_ready;
    op_done   = hs && (is_red || (res_rem == CNT_W'(1)));
    last_beat = issue_en && (beat_rem == CNT_W'(1));
    case (out_sel)
      3'b100:  lat_load = LAT_W'(LAT_ACC - 1);
      3'b101:  lat_load = LAT_W'(LAT_NL - 1);
      default: lat_load = LAT_W'(K - 1);
    endcase
    case (state)
      S_IDLE:  if (accept && legal) state_nxt = S_ISSUE;
      S_ISSUE: if (last_beat) state_nxt = S_DRAIN;
      S_DRAIN: if (op_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_rem <= '0;
      res_rem  <= '0;
      is_red   <= 1'b0;
      lat_cnt  <= '0;
      tok      <= '0;
      out_sel  <= 3'b000;
      err_op   <= 1'b0;
    end else begin
      err_op <= accept && !legal;
      if (accept && legal) begin
        beat_rem <= op_len;
        res_rem  <= op_len;
        is_red   <= op_code[2];
        out_sel  <= op_code;
      end else begin
        if (issue_en) beat_rem <= beat_rem - CNT_W'(1);
        if (hs && !is_red) res_rem <= res_rem - CNT_W'(1);
        if (op_done) out_sel <= 3'b000;
      end
      // Token pipe only carries vector beats; reductions report via lat_cnt.
      if (pipe_en) tok <= (tok << 1) | LAT_VEC'(issue_en && !is_red);
      if (last_beat && is_red) begin
        lat_cnt <= lat_load;
      end else if ((state == S_DRAIN) && pipe_en && (lat_cnt != '0)) begin
        lat_cnt <= lat_cnt - LAT_W'(1);
      end
    end
  end

`ifdef SEL_CTRL_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= '0;
    end else if ((state != S_IDLE) && !pipe_en && (perf_stall_cnt != 32'hFFFF_FFFF)) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mlu_sel_ctrl.sv
// Bench for mlu_sel_ctrl: per-cycle reference model plus hand-computed timing vectors.
module tb_mlu_sel_ctrl;

  localparam int CNT_W   = 8;
  localparam int K       = 20;
  localparam int LAT_VEC = 3;
  localparam int LAT_ACC = 5;
  localparam int LAT_NL  = 4;
  localparam int LOG_N   = 4096;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             op_valid = 1'b0;
  logic             op_ready;
  logic [2:0]       op_code = 3'b000;
  logic [CNT_W-1:0] op_len = '0;
  logic             issue_en;
  logic             pipe_en;
  logic [2:0]       out_sel;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic             op_done;
  logic             err_op;
  logic [1:0]       dbg_state;
`ifdef SEL_CTRL_PERF_EN
  logic [31:0]      perf_stall_cnt;
`endif

  mlu_sel_ctrl #(.K(K), .CNT_W(CNT_W), .LAT_VEC(LAT_VEC), .LAT_ACC(LAT_ACC), .LAT_NL(LAT_NL)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code),
    .op_len(op_len), .issue_en(issue_en), .pipe_en(pipe_en), .out_sel(out_sel),
    .res_valid(res_valid), .res_ready(res_ready), .op_done(op_done), .err_op(err_op),
`ifdef SEL_CTRL_PERF_EN
    .perf_stall_cnt(perf_stall_cnt),
`endif
    .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", name, cyc, got, exp);
    else n_pass++;
  endtask

  // scoreboard: expected-output model and per-cycle logs
  bit         log_issue[LOG_N];
  bit         log_valid[LOG_N];
  bit         log_done[LOG_N];
  bit         log_err[LOG_N];
  bit         log_pipe[LOG_N];
  logic [2:0] log_sel[LOG_N];

  bit         m_busy, m_red, m_err;
  int         m_len, m_issued, m_got, m_red_cnt, m_lat;
  logic [2:0] m_sel;
  int         m_tok[$];
  logic [31:0] m_stall;
  bit         e_valid, e_pipe, e_issue, e_done, hs, m_ready;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < LOG_N) begin
      log_issue[cyc] = issue_en;
      log_valid[cyc] = res_valid;
      log_done[cyc]  = op_done;
      log_err[cyc]   = err_op;
      log_pipe[cyc]  = pipe_en;
      log_sel[cyc]   = out_sel;
    end
    if (!rst_n) begin
      m_busy = 0; m_red = 0; m_err = 0; m_len = 0; m_issued = 0; m_got = 0;
      m_red_cnt = -1; m_lat = 0; m_sel = 3'b000; m_tok.delete(); m_stall = '0;
      check("rst_issue_en", issue_en, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_op_done", op_done, 0);
      check("rst_err_op", err_op, 0);
      check("rst_out_sel", out_sel, 0);
      check("rst_op_ready", op_ready, 1);
    end else begin
      m_ready = !m_busy;
      if (m_red) e_valid = m_busy && (m_red_cnt == 0);
      else       e_valid = (m_tok.size() > 0) && (m_tok[0] == 0);
      e_pipe  = !(e_valid && !res_ready);
      e_issue = m_busy && (m_issued < m_len) && e_pipe;
      hs      = e_valid && res_ready;
      e_done  = hs && ((m_got + 1) == (m_red ? 1 : m_len));
      check("op_ready", op_ready, m_ready);
      check("issue_en", issue_en, e_issue);
      check("pipe_en", pipe_en, e_pipe);
      check("res_valid", res_valid, e_valid);
      check("op_done", op_done, e_done);
      check("err_op", err_op, m_err);
      check("out_sel", out_sel, m_sel);
`ifdef SEL_CTRL_PERF_EN
      check("perf_stall_cnt", perf_stall_cnt, m_stall);
`endif
      if (m_busy && !e_pipe && m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
      if (e_pipe) begin
        if (hs) begin
          m_got++;
          if (!m_red) void'(m_tok.pop_front());
        end
        foreach (m_tok[i]) if (m_tok[i] > 0) m_tok[i]--;
        if (e_issue) begin
          m_issued++;
          if (!m_red) m_tok.push_back(LAT_VEC - 1);
          else if (m_issued == m_len) m_red_cnt = m_lat - 1;
        end else if (m_red && m_red_cnt > 0) begin
          m_red_cnt--;
        end
      end
      if (e_done) begin
        m_busy = 0; m_sel = 3'b000; m_red_cnt = -1; m_tok.delete();
      end
      m_err = 0;
      if (op_valid && m_ready) begin
        if (op_code == 3'b000 || op_code == 3'b111 || op_len == 0) begin
          m_err = 1;
        end else begin
          m_busy = 1; m_sel = op_code; m_len = op_len; m_issued = 0; m_got = 0;
          m_red = (op_code >= 3'b100); m_red_cnt = -1; m_tok.delete();
          m_lat = (op_code == 3'b100) ? LAT_ACC : (op_code == 3'b101) ? LAT_NL : K;
        end
      end
    end
  end

  // driver tasks
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      op_valid = 0; res_ready = 1;
    end
    @(negedge clk);
  endtask

  task automatic run_op(input logic [2:0] code, input int len, input int st_from, input int st_to,
                        input int budget, output int c0, output bit seen);
    @(posedge clk); #1;
    op_valid = 1; op_code = code; op_len = len[CNT_W-1:0]; res_ready = 1; c0 = cyc;
    seen = 0;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk); #1;
      op_valid = 0;
      res_ready = !(k >= st_from && k <= st_to);
      @(negedge clk);
      if (op_done) begin
        seen = 1;
        break;
      end
    end
    res_ready = 1;
  endtask

  task automatic lit_vec(input string name, input int which, input int c0, input int n,
                         input logic [31:0] exp);
    logic [31:0] got;
    got = '0;
    for (int k = 0; k < n; k++) begin
      int idx;
      idx = c0 + k;
      case (which)
        0:       got[k] = log_issue[idx];
        1:       got[k] = log_valid[idx];
        2:       got[k] = log_done[idx];
        3:       got[k] = log_err[idx];
        default: got[k] = log_pipe[idx];
      endcase
    end
    check(name, got, exp);
  endtask

  int c0, c1, icount;
  bit seen;

  initial begin
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    check("post_reset_op_ready", op_ready, 1);
    check("post_reset_out_sel", out_sel, 0);
    idle(4);

    // add, 4 beats, no backpressure
    run_op(3'b010, 4, 0, -1, 20, c0, seen);
    check("add4_done_seen", seen, 1);
    idle(3);
    lit_vec("add4_issue", 0, c0, 10, 32'h01E);
    lit_vec("add4_valid", 1, c0, 10, 32'h0F0);
    lit_vec("add4_done", 2, c0, 10, 32'h080);
    check("add4_sel_c1", log_sel[c0 + 1], 3'b010);
    check("add4_sel_c7", log_sel[c0 + 7], 3'b010);
    check("add4_sel_c8", log_sel[c0 + 8], 3'b000);

    // acc, 3 beats
    run_op(3'b100, 3, 0, -1, 20, c0, seen);
    check("acc3_done_seen", seen, 1);
    idle(2);
    lit_vec("acc3_issue", 0, c0, 10, 32'h00E);
    lit_vec("acc3_valid", 1, c0, 10, 32'h100);
    lit_vec("acc3_done", 2, c0, 10, 32'h100);

    // mul, 2 beats, downstream stalls c4..c6
    run_op(3'b011, 2, 4, 6, 20, c0, seen);
    check("mul2_done_seen", seen, 1);
`ifdef SEL_CTRL_PERF_EN
    check("mul2_perf_stall", perf_stall_cnt, 32'd3);
`endif
    idle(2);
    lit_vec("mul2_pipe", 4, c0, 10, 32'h38F);
    lit_vec("mul2_valid", 1, c0, 10, 32'h1F0);
    lit_vec("mul2_done", 2, c0, 10, 32'h100);

    // illegal opcode, then a legal cnt op right after
    run_op(3'b111, 3, 0, -1, 3, c0, seen);
    check("ill111_no_done", seen, 0);
    run_op(3'b001, 1, 0, -1, 10, c1, seen);
    check("cnt1_done_seen", seen, 1);
    idle(2);
    lit_vec("ill111_err", 3, c0, 4, 32'h2);
    lit_vec("ill111_issue", 0, c0, 4, 32'h0);
    lit_vec("cnt1_issue", 0, c1, 6, 32'h02);
    lit_vec("cnt1_done", 2, c1, 6, 32'h10);

    // zero-length descriptor
    run_op(3'b010, 0, 0, -1, 3, c0, seen);
    check("len0_no_done", seen, 0);
    idle(1);
    lit_vec("len0_err", 3, c0, 4, 32'h2);
    lit_vec("len0_issue", 0, c0, 4, 32'h0);

    // nonlin, 2 beats
    run_op(3'b101, 2, 0, -1, 20, c0, seen);
    check("nl2_done_seen", seen, 1);
    idle(2);
    lit_vec("nl2_valid", 1, c0, 8, 32'h40);
    lit_vec("nl2_done", 2, c0, 8, 32'h40);

    // add, 6 beats, stall while still issuing; back-to-back with next op
    run_op(3'b010, 6, 5, 6, 30, c0, seen);
    check("add6_done_seen", seen, 1);
    run_op(3'b011, 1, 0, -1, 10, c1, seen);
    check("b2b_done_seen", seen, 1);
    idle(2);
    lit_vec("add6_issue", 0, c0, 12, 32'h19E);
    lit_vec("add6_valid", 1, c0, 12, 32'hFF0);
    lit_vec("add6_done", 2, c0, 12, 32'h800);
    lit_vec("b2b_issue", 0, c1, 6, 32'h02);

    // maximum beat count for this width
    run_op(3'b001, (1 << CNT_W) - 1, 0, -1, 300, c0, seen);
    check("max_done_seen", seen, 1);
    idle(2);
    icount = 0;
    for (int k = 1; k < 300; k++) icount += log_issue[c0 + k];
    check("max_issue_cnt", icount, (1 << CNT_W) - 1);
    check("max_done_cyc", log_done[c0 + (1 << CNT_W) - 1 + LAT_VEC], 1);

    // ksort, reset lands mid-issue
    run_op(3'b110, 5, 0, -1, 3, c0, seen);
    check("ks_pre_rst_no_done", seen, 0);
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    check("ks_async_issue", issue_en, 0);
    check("ks_async_sel", out_sel, 0);
    check("ks_async_valid", res_valid, 0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;
    idle(2);
    run_op(3'b110, 1, 0, -1, 40, c0, seen);
    check("ks1_done_seen", seen, 1);
    idle(2);
    lit_vec("ks1_issue", 0, c0, 23, 32'h2);
    lit_vec("ks1_valid", 1, c0, 23, 32'h0020_0000);
    lit_vec("ks1_done", 2, c0, 23, 32'h0020_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
